// File: rtl/array_pkg.sv
// Shared definitions for the bit-serial PE array sequencer:
// opcodes, instruction field positions and sequencer states.
package array_pkg;

    localparam int REG_INDEX_W = 5;
    localparam int OPC_W       = 6;

    localparam int OPC_LSB  = 26;
    localparam int SRCA_LSB = 21;
    localparam int DST_LSB  = 16;
    localparam int SRCB_LSB = 11;

    localparam logic [OPC_W-1:0] OP_NOP = 6'd0;
    localparam logic [OPC_W-1:0] OP_ADD = 6'd1;
    localparam logic [OPC_W-1:0] OP_SUB = 6'd2;
    localparam logic [OPC_W-1:0] OP_AND = 6'd3;
    localparam logic [OPC_W-1:0] OP_OR  = 6'd4;
    localparam logic [OPC_W-1:0] OP_XOR = 6'd5;
    localparam logic [OPC_W-1:0] OP_MOV = 6'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic [5:0] clamp_len(input logic [5:0] len,
                                             input logic [5:0] max_len);
        return (len == 6'd0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/array_instr_decode.sv
// Combinational instruction splitter: fields, illegal/NOP flags,
// zero-mask expansion and carry preset.
import array_pkg::*;

module array_instr_decode #(
    parameter int SIZE = 4
) (
    input  logic [31:0]            instr_i,
    output logic [OPC_W-1:0]       op_o,
    output logic [REG_INDEX_W-1:0] src_a_o,
    output logic [REG_INDEX_W-1:0] dst_o,
    output logic [REG_INDEX_W-1:0] src_b_o,
    output logic [SIZE-1:0]        mask_o,
    output logic                   illegal_o,
    output logic                   nop_o,
    output logic                   carry_init_o
);

    logic unused_bits;

    assign op_o    = instr_i[OPC_LSB  +: OPC_W];
    assign src_a_o = instr_i[SRCA_LSB +: REG_INDEX_W];
    assign dst_o   = instr_i[DST_LSB  +: REG_INDEX_W];
    assign src_b_o = instr_i[SRCB_LSB +: REG_INDEX_W];

    // An all-zero mask means broadcast to every PE.
    assign mask_o = (instr_i[SIZE-1:0] == '0) ? '1 : instr_i[SIZE-1:0];

    assign illegal_o    = (op_o > OP_MOV);
    assign nop_o        = (op_o == OP_NOP);
    assign carry_init_o = (op_o == OP_SUB);

    assign unused_bits = ^instr_i[SRCB_LSB-1:SIZE];

endmodule

// File: rtl/array_seq_ctrl.sv
// Bit-serial PE array sequencer: latches one instruction on a start
// edge and steps the array one bit-plane per cycle.
import array_pkg::*;

module array_seq_ctrl #(
    parameter int SIZE            = 4,
    parameter int MAX_WORD_LENGTH = 32,
    parameter int REG_ADDR_W      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           instruction,
    input  logic [5:0]            length,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [SIZE-1:0]       pe_en,
    output logic [5:0]            pe_op,
    output logic [4:0]            pe_bit_idx,
    output logic [REG_ADDR_W-1:0] pe_src_a_addr,
    output logic [REG_ADDR_W-1:0] pe_src_b_addr,
    output logic [REG_ADDR_W-1:0] pe_dst_addr,
    output logic                  pe_first,
    output logic                  pe_last,
    output logic                  carry_init
);

    localparam logic [5:0] MAX_LEN = 6'(MAX_WORD_LENGTH);

    logic [OPC_W-1:0]       dec_op;
    logic [REG_INDEX_W-1:0] dec_a, dec_d, dec_b;
    logic [SIZE-1:0]        dec_mask;
    logic                   dec_illegal, dec_nop, dec_sub;

    array_instr_decode #(.SIZE(SIZE)) u_dec (
        .instr_i      (instruction),
        .op_o         (dec_op),
        .src_a_o      (dec_a),
        .dst_o        (dec_d),
        .src_b_o      (dec_b),
        .mask_o       (dec_mask),
        .illegal_o    (dec_illegal),
        .nop_o        (dec_nop),
        .carry_init_o (dec_sub)
    );

    state_e                 state_q;
    logic                   start_prev_q, launch_q;
    logic [OPC_W-1:0]       op_q;
    logic [REG_INDEX_W-1:0] a_q, d_q, b_q;
    logic [SIZE-1:0]        mask_q;
    logic                   illegal_q, skip_q, sub_q;
    logic [5:0]             len_q;
    logic [4:0]             bit_q;

    logic                   launch_d, step_d, last_d;
    logic [4:0]             bit_d;

    function automatic logic [REG_ADDR_W-1:0] addr(
        input logic [REG_INDEX_W-1:0] r,
        input logic [4:0]             b
    );
        return REG_ADDR_W'(r) * REG_ADDR_W'(MAX_WORD_LENGTH) + REG_ADDR_W'(b);
    endfunction

    // A pending launch blocks further edges until DECODE is entered.
    assign launch_d = start && !start_prev_q && (state_q == S_IDLE) && !launch_q;
    assign step_d   = ((state_q == S_DECODE) && !skip_q) ||
                      ((state_q == S_EXEC) && !pe_last);
    assign bit_d    = (state_q == S_DECODE) ? 5'd0 : bit_q;
    assign last_d   = ({1'b0, bit_d} == len_q - 6'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_prev_q  <= 1'b0;
            launch_q      <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            d_q           <= '0;
            b_q           <= '0;
            mask_q        <= '0;
            illegal_q     <= 1'b0;
            skip_q        <= 1'b0;
            sub_q         <= 1'b0;
            len_q         <= '0;
            bit_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            pe_en         <= '0;
            pe_op         <= '0;
            pe_bit_idx    <= '0;
            pe_src_a_addr <= '0;
            pe_src_b_addr <= '0;
            pe_dst_addr   <= '0;
            pe_first      <= 1'b0;
            pe_last       <= 1'b0;
            carry_init    <= 1'b0;
        end else begin
            start_prev_q <= start;
            launch_q     <= launch_d;
            done         <= 1'b0;
            pe_en        <= '0;
            pe_first     <= 1'b0;
            pe_last      <= 1'b0;
            carry_init   <= 1'b0;

            if (launch_d) begin
                op_q      <= dec_op;
                a_q       <= dec_a;
                d_q       <= dec_d;
                b_q       <= dec_b;
                mask_q    <= dec_mask;
                illegal_q <= dec_illegal;
                skip_q    <= dec_illegal || dec_nop;
                sub_q     <= dec_sub;
                len_q     <= clamp_len(length, MAX_LEN);
            end

            if (step_d) begin
                pe_en         <= mask_q;
                pe_op         <= op_q;
                pe_bit_idx    <= bit_d;
                pe_src_a_addr <= addr(a_q, bit_d);
                pe_src_b_addr <= addr(b_q, bit_d);
                pe_dst_addr   <= addr(d_q, bit_d);
                pe_first      <= (bit_d == 5'd0);
                pe_last       <= last_d;
                carry_init    <= sub_q && (bit_d == 5'd0);
                bit_q         <= bit_d + 5'd1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (launch_q) begin
                        state_q <= S_DECODE;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                S_DECODE: begin
                    if (skip_q) begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                        err     <= illegal_q;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (pe_last) begin
                        state_q <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_seq_ctrl.sv
// Directed bench for array_seq_ctrl: vector table plus hand-written
// sequences for held start, busy re-trigger and mid-run reset.
module tb_array_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] instruction;
    logic [5:0]  length;
    logic        busy, done, err;
    logic [3:0]  pe_en;
    logic [5:0]  pe_op;
    logic [4:0]  pe_bit_idx;
    logic [9:0]  pe_src_a_addr, pe_src_b_addr, pe_dst_addr;
    logic        pe_first, pe_last, carry_init;

    array_seq_ctrl #(.SIZE(4), .MAX_WORD_LENGTH(32), .REG_ADDR_W(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .instruction   (instruction),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .pe_en         (pe_en),
        .pe_op         (pe_op),
        .pe_bit_idx    (pe_bit_idx),
        .pe_src_a_addr (pe_src_a_addr),
        .pe_src_b_addr (pe_src_b_addr),
        .pe_dst_addr   (pe_dst_addr),
        .pe_first      (pe_first),
        .pe_last       (pe_last),
        .carry_init    (carry_init)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [5:0] op;
        logic [4:0] a;
        logic [4:0] d;
        logic [4:0] b;
        logic [3:0] mask;
        logic [5:0] len;
        int         exp_len;
        logic [3:0] exp_mask;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];
    vec_t v_held, v_sub, v_rst;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input vec_t v);
        return {v.op, v.a, v.d, v.b, 7'd0, v.mask};
    endfunction

    // Called just after the launch edge; follows the whole instruction.
    task automatic observe(input vec_t v);
        int L;
        int d0;
        logic [4:0] b;
        L  = (v.op == 6'd0 || v.op > 6'd6) ? 0 : v.exp_len;
        d0 = done_cnt;
        for (int c = 1; c <= L + 3; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                chk("busy_decode", 32'(busy), 1);
                chk("done_decode", 32'(done), 0);
                chk("en_decode", 32'(pe_en), 0);
                chk("err_cleared", 32'(err), 0);
            end else if (c <= L + 1) begin
                b = 5'(c - 2);
                chk("exec_busy", 32'(busy), 1);
                chk("exec_done", 32'(done), 0);
                chk("exec_en", 32'(pe_en), 32'(v.exp_mask));
                chk("exec_op", 32'(pe_op), 32'(v.op));
                chk("bit_idx", 32'(pe_bit_idx), 32'(b));
                chk("src_a_addr", 32'(pe_src_a_addr), 32'(v.a) * 32 + 32'(b));
                chk("src_b_addr", 32'(pe_src_b_addr), 32'(v.b) * 32 + 32'(b));
                chk("dst_addr", 32'(pe_dst_addr), 32'(v.d) * 32 + 32'(b));
                chk("first", 32'(pe_first), 32'(b == 5'd0));
                chk("last", 32'(pe_last), 32'(int'(b) == L - 1));
                chk("carry_init", 32'(carry_init),
                    32'((b == 5'd0) && (v.op == 6'd2)));
            end else if (c == L + 2) begin
                chk("done_pulse", 32'(done), 1);
                chk("busy_done", 32'(busy), 1);
                chk("err_done", 32'(err), 32'(v.exp_err));
                chk("en_done", 32'(pe_en), 0);
                chk("first_done", 32'(pe_first), 0);
                chk("last_done", 32'(pe_last), 0);
                chk("carry_done", 32'(carry_init), 0);
                if (L > 0)
                    chk("dst_hold", 32'(pe_dst_addr), 32'(v.d) * 32 + 32'(L - 1));
            end else begin
                chk("busy_idle", 32'(busy), 0);
                chk("done_idle", 32'(done), 0);
                chk("err_hold", 32'(err), 32'(v.exp_err));
            end
        end
        chk("done_count", 32'(done_cnt - d0), 1);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        instruction = mk(v);
        length      = v.len;
        start       = 1'b1;
        @(posedge clk); #1;
        chk("idle_at_launch", 32'(busy), 0);
        @(negedge clk);
        start       = 1'b0;
        instruction = 32'hFFFF_FFFF;
        length      = 6'd3;
        observe(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        vecs[0] = '{6'd2, 5'd1,  5'd4,  5'd3,  4'h0, 6'd32, 32, 4'hF, 1'b0};
        vecs[1] = '{6'd1, 5'd2,  5'd5,  5'd7,  4'h5, 6'd1,  1,  4'h5, 1'b0};
        vecs[2] = '{6'd3, 5'd0,  5'd31, 5'd31, 4'h0, 6'd0,  32, 4'hF, 1'b0};
        vecs[3] = '{6'd4, 5'd31, 5'd0,  5'd1,  4'h8, 6'd40, 32, 4'h8, 1'b0};
        vecs[4] = '{6'd5, 5'd6,  5'd7,  5'd8,  4'h3, 6'd16, 16, 4'h3, 1'b0};
        vecs[5] = '{6'h3F, 5'd1, 5'd2,  5'd3,  4'h1, 6'd8,  8,  4'h1, 1'b1};
        vecs[6] = '{6'd6, 5'd9,  5'd10, 5'd11, 4'h2, 6'd2,  2,  4'h2, 1'b0};
        vecs[7] = '{6'd0, 5'd1,  5'd1,  5'd1,  4'h0, 6'd5,  5,  4'hF, 1'b0};
        vecs[8] = '{6'd7, 5'd3,  5'd3,  5'd3,  4'h0, 6'd1,  1,  4'hF, 1'b1};
        vecs[9] = '{6'd2, 5'd31, 5'd31, 5'd31, 4'hF, 6'd31, 31, 4'hF, 1'b0};
        v_held  = '{6'd1, 5'd1,  5'd2,  5'd3,  4'h0, 6'd8,  8,  4'hF, 1'b0};
        v_sub   = '{6'd2, 5'd1,  5'd4,  5'd3,  4'h0, 6'd32, 32, 4'hF, 1'b0};
        v_rst   = '{6'd5, 5'd2,  5'd3,  5'd4,  4'h6, 6'd4,  4,  4'h6, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        instruction = '0;
        length = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_en", 32'(pe_en), 0);
        chk("rst_op", 32'(pe_op), 0);
        chk("rst_dst", 32'(pe_dst_addr), 0);
        chk("rst_first_last", 32'({pe_first, pe_last, carry_init}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Start held high for a long time runs exactly once.
        d0 = done_cnt;
        @(negedge clk);
        instruction = mk(v_held);
        length = v_held.len;
        start = 1'b1;
        repeat (2000) @(negedge clk);
        start = 1'b0;
        chk("held_single_run", 32'(done_cnt - d0), 1);
        chk("held_idle", 32'(busy), 0);

        // Second rising edge while busy is dropped.
        d0 = done_cnt;
        @(negedge clk);
        instruction = mk(v_sub);
        length = v_sub.len;
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        chk("busy_edge_ignored", 32'(done_cnt - d0), 1);

        run_vec(vecs[1]);

        // Reset mid-EXEC with start still high at release.
        @(negedge clk);
        instruction = mk(v_sub);
        length = v_sub.len;
        start = 1'b1;
        @(posedge clk); #1;
        d0 = done_cnt;
        repeat (12) @(posedge clk);
        #1;
        chk("pre_reset_bit", 32'(pe_bit_idx), 10);
        chk("pre_reset_busy", 32'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_en", 32'(pe_en), 0);
        chk("abort_addr", 32'(pe_src_a_addr | pe_src_b_addr | pe_dst_addr), 0);
        chk("abort_misc", 32'({done, err, pe_op, pe_bit_idx, pe_first, pe_last, carry_init}), 0);
        @(negedge clk);
        reset = 1'b0;
        instruction = mk(v_rst);
        length = v_rst.len;
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        chk("relaunch_idle", 32'(busy), 0);
        observe(v_rst);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_seq_ctrl.md
Name: array_seq_ctrl

Overview:
Instruction sequencer for the bit-serial PE array. It latches one 32-bit instruction and a word length on a start edge. It then steps the array through one bit per cycle, driving per-bit register addresses, opcode, PE enables and carry control. It sits between the host/instruction source and the PE array plus register file, and signals completion with a one-cycle done pulse.

Parameters:
SIZE, 4, number of PEs (width of PE enable mask)
MAX_WORD_LENGTH, 32, maximum bits per word; register stride in the bit-plane address space
REG_ADDR_W, 10, register-file bit address width (5-bit reg index x 32 bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  level input; rising edge launches an instruction
instruction  in  32  [31:26] opcode, [25:21] src_a, [20:16] dst, [15:11] src_b, [SIZE-1:0] PE mask (0 = all PEs)
length  in  6  word length in bits; 0 or >MAX_WORD_LENGTH clamps to MAX_WORD_LENGTH
busy  out  1  high from DECODE through DONE
done  out  1  one-cycle pulse at end of instruction
err  out  1  set with done when opcode is illegal; cleared on next launch
pe_en  out  SIZE  per-PE enable, valid only in EXEC
pe_op  out  6  latched opcode, valid in EXEC
pe_bit_idx  out  5  current bit index
pe_src_a_addr  out  REG_ADDR_W  src_a*MAX_WORD_LENGTH + bit index
pe_src_b_addr  out  REG_ADDR_W  src_b*MAX_WORD_LENGTH + bit index
pe_dst_addr  out  REG_ADDR_W  dst*MAX_WORD_LENGTH + bit index
pe_first  out  1  high on bit 0 of EXEC
pe_last  out  1  high on final bit of EXEC
carry_init  out  1  carry preset value, valid with pe_first (1 for SUB, else 0)

Behaviour:
- Reset: state IDLE; all outputs 0; start_prev cleared to 0. A start held high through reset release therefore launches once. Reset mid-EXEC aborts immediately with no done pulse.
- Launch condition: start=1 and start_prev=0 while in IDLE. Edges while busy are ignored and not queued. Re-launch requires start low for at least one cycle.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV. 7-63 are illegal.
- IDLE -> DECODE on launch edge:
  - latch instruction fields;
  - latch eff_len = clamp(length);
  - latch mask (0 expands to all ones).
- DECODE (1 cycle):
  - illegal opcode or NOP -> DONE; err=1 for illegal only;
  - otherwise -> EXEC with bit=0.
- EXEC: one bit per cycle, bit = 0..eff_len-1.
  - pe_en=mask; addresses = reg*MAX_WORD_LENGTH+bit, computed at full REG_ADDR_W width with no wrap.
  - pe_first at bit 0; pe_last at bit eff_len-1; both high together when eff_len=1.
  - After pe_last -> DONE.
- DONE (1 cycle): done=1, busy=1, pe_en=0. Then -> IDLE with busy=0.
- Latency: launch edge sampled at clock edge k; EXEC bit 0 visible after edge k+2; done visible after edge k+2+eff_len. Total busy cycles = eff_len+2, or 2 for NOP/illegal.
- Outside EXEC, pe_en, pe_first, pe_last and carry_init are 0; addresses and pe_op hold their last value.
- Inputs instruction and length are sampled only on the launch edge; later changes have no effect mid-instruction.

Decomposition:
- Shared package array_pkg:
  - opcode constants;
  - instruction field bit positions;
  - state encoding (IDLE, DECODE, EXEC, DONE);
  - REG_INDEX_W=5.
- One combinational sub-module, array_instr_decode: splits instruction into fields, flags illegal opcodes, expands a zero mask, and produces carry_init.
- Counter and FSM stay in array_seq_ctrl.

Test Plan:
- instruction=32'h08241800 (SUB, src_a=1, dst=4, src_b=3, mask 0), length=32, start pulse -> pe_en=4'b1111 and carry_init=1 on first bit. Src_a addr 32..63, src_b 96..127, dst 128..159 over 32 EXEC cycles. done after edge k+34.
- ADD with mask 4'b0101, length=1 -> single EXEC cycle with pe_first=pe_last=1, carry_init=0, pe_en=0101; done one cycle later.
- length=0 and length=40 -> both run 32 EXEC cycles; length=16 -> 16 cycles, last dst addr = dst*32+15.
- Opcode 6'h3F -> no EXEC cycles; done=1 and err=1 two cycles after launch. A following valid launch clears err.
- start held high for 2000 cycles -> exactly one instruction executes. A second rising edge during busy is ignored. Re-raising start after idle launches again.
- reset asserted mid-EXEC at bit 10 -> next cycle all outputs 0, no done, state IDLE. Start still high at reset release launches a fresh instruction.
